// File: rtl/minimization_checker_if.sv
// Handshake/result bundle between the minimization checker (master) and the
// logic under test plus its controller (slave).
interface minimization_checker_if;
  logic       start;
  logic       o1;
  logic       o0;
  logic       i2;
  logic       i1;
  logic       i0;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [7:0] fail_map;

  modport master (
    input  start, o1, o0,
    output i2, i1, i0, busy, done, pass, err_cnt, fail_map
  );

  modport slave (
    output start, o1, o0,
    input  i2, i1, i0, busy, done, pass, err_cnt, fail_map
  );
endinterface

// File: rtl/minimization_checker.sv
// Sweeps {i2,i1,i0} through 0..7, samples {o1,o0} after a settle interval and
// compares against EXPECTED. Optional macro MINCHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module minimization_checker #(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'h6E76
) (
  input  logic                  clk,
  input  logic                  rst,
  minimization_checker_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_vec;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err;
  logic [7:0] r_fail;

  logic [1:0] w_exp;
  logic       w_mis;
  logic [3:0] w_err_nxt;
  logic       w_last;

  assign w_exp     = 2'(EXPECTED >> {r_vec, 1'b0});
  assign w_mis     = ({bus.o1, bus.o0} != w_exp);
  assign w_err_nxt = r_err + {3'b000, w_mis};

`ifdef MINCHK_STOP_ON_FAIL_EN
  assign w_last = (r_vec == 3'd7) || w_mis;
`else
  assign w_last = (r_vec == 3'd7);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fail  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_SETTLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(SETTLE - 1)) r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_err  <= w_err_nxt;
          r_fail <= r_fail | (8'(w_mis) << r_vec);
          // pass reflects the count including this final comparison
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 4'd0);
          end else begin
            r_vec   <= r_vec + 3'd1;
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.i2       = r_vec[2];
  assign bus.i1       = r_vec[1];
  assign bus.i0       = r_vec[0];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.err_cnt  = r_err;
  assign bus.fail_map = r_fail;

endmodule

// File: tb/tb_minimization_checker.sv
// Bench for minimization_checker: two instances (SETTLE=2 and SETTLE=1) driven
// by table-based responders, checked against a per-vector reference model.
module tb_minimization_checker;

`ifdef MINCHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  minimization_checker_if ifa ();
  minimization_checker_if ifb ();

  minimization_checker #(.SETTLE(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  minimization_checker #(.SETTLE(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  logic [15:0] tab_a = '0;
  logic [15:0] tab_b = '0;
  logic [2:0]  ka, kb;
  assign ka     = {ifa.i2, ifa.i1, ifa.i0};
  assign kb     = {ifb.i2, ifb.i1, ifb.i0};
  assign ifa.o1 = tab_a[{ka, 1'b1}];
  assign ifa.o0 = tab_a[{ka, 1'b0}];
  assign ifb.o1 = tab_b[{kb, 1'b1}];
  assign ifb.o0 = tab_b[{kb, 1'b0}];

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] golden(input logic [2:0] k);
    logic o1, o0;
    o1 = (k[2] & ~k[1]) | ~k[0];
    o0 = k[0] | (k[1] & ~k[2]);
    return {o1, o0};
  endfunction

  function automatic logic [15:0] make_tab(input int mode);
    logic [15:0] t;
    logic [1:0]  g;
    t = '0;
    for (int k = 0; k < 8; k++) begin
      g = golden(3'(k));
      case (mode)
        1:       t[2*k +: 2] = {g[1], 1'b0};
        2:       t[2*k +: 2] = {~g[1], g[0]};
        default: t[2*k +: 2] = g;
      endcase
    end
    return t;
  endfunction

  task automatic model(input logic [15:0] tab, input int s, output int e,
                       output int m, output int fv, output int dc);
    e  = 0;
    m  = 0;
    fv = 7;
    for (int k = 0; k < 8; k++) begin
      if (tab[2*k +: 2] != golden(3'(k))) begin
        e++;
        m = m | (1 << k);
        if (STOP) begin
          fv = k;
          break;
        end
      end
    end
    dc = (fv + 1) * (s + 1) + 1;
  endtask

  task automatic sample(input int w, output int v, output int b, output int d,
                        output int p, output int e, output int m);
    if (w == 0) begin
      v = int'(ka); b = int'(ifa.busy); d = int'(ifa.done);
      p = int'(ifa.pass); e = int'(ifa.err_cnt); m = int'(ifa.fail_map);
    end else begin
      v = int'(kb); b = int'(ifb.busy); d = int'(ifb.done);
      p = int'(ifb.pass); e = int'(ifb.err_cnt); m = int'(ifb.fail_map);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) ifa.start = v;
    else        ifb.start = v;
  endtask

  task automatic check_reset(input int w, input string tag);
    int v, b, d, p, e, m;
    sample(w, v, b, d, p, e, m);
    check_eq({tag, "_vec"},  v, 0);
    check_eq({tag, "_busy"}, b, 0);
    check_eq({tag, "_done"}, d, 0);
    check_eq({tag, "_pass"}, p, 0);
    check_eq({tag, "_err"},  e, 0);
    check_eq({tag, "_map"},  m, 0);
  endtask

  // One sweep from IDLE; optional re-start pulse mid-sweep and start held in DONE.
  task automatic run_sweep(input int w, input logic [15:0] tab, input int restart_cyc,
                           input bit start_in_done, input string tag);
    int s, e_exp, m_exp, fv, dc, exp_vec;
    int v, b, d, p, e, m;
    int n_done, done_at, vec_bad;
    s = (w == 0) ? 2 : 1;
    if (w == 0) tab_a = tab;
    else        tab_b = tab;
    model(tab, s, e_exp, m_exp, fv, dc);
    n_done  = 0;
    done_at = -1;
    vec_bad = 0;
    @(negedge clk);
    set_start(w, 1'b1);
    for (int c = 1; c <= dc + 2; c++) begin
      @(negedge clk);
      set_start(w, (c == restart_cyc) || (start_in_done && c == dc));
      sample(w, v, b, d, p, e, m);
      if (d == 1) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      exp_vec = (c < dc) ? (c - 1) / (s + 1) : fv;
      if (v != exp_vec) vec_bad++;
      if (c == 1) check_eq({tag, "_busy_c1"}, b, 1);
      if (c == dc) begin
        check_eq({tag, "_busy_done"}, b, 1);
        check_eq({tag, "_pass"}, p, (e_exp == 0) ? 1 : 0);
        check_eq({tag, "_err"},  e, e_exp);
        check_eq({tag, "_map"},  m, m_exp);
      end
      if (c == dc + 1) check_eq({tag, "_busy_fall"}, b, 0);
      if (c == dc + 2) begin
        check_eq({tag, "_busy_idle"}, b, 0);
        check_eq({tag, "_err_hold"},  e, e_exp);
        check_eq({tag, "_map_hold"},  m, m_exp);
        check_eq({tag, "_vec_hold"},  v, fv);
      end
    end
    set_start(w, 1'b0);
    check_eq({tag, "_stim_seq_errs"}, vec_bad, 0);
    check_eq({tag, "_done_count"},    n_done, 1);
    check_eq({tag, "_done_cycle"},    done_at, dc);
  endtask

  initial begin
    int v, b, d, p, e, m;
    logic [15:0] gold, rt;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    gold  = make_tab(0);
    tab_a = gold;
    tab_b = gold;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset(0, "rstA");
    check_reset(1, "rstB");

    run_sweep(0, gold, -1, 1'b0, "goodA");
    run_sweep(0, make_tab(1), -1, 1'b0, "o0stuckA");

    // Reset during vector 4 (cycles 13..15 with SETTLE=2)
    tab_a = gold;
    @(negedge clk);
    ifa.start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      ifa.start = 1'b0;
    end
    sample(0, v, b, d, p, e, m);
    check_eq("midrst_vec_before", v, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset(0, "midrst");
    @(negedge clk);
    check_eq("midrst_idle_busy", int'(ifa.busy), 0);

    // start and rst together: reset wins
    rst = 1'b1;
    ifa.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifa.start = 1'b0;
    check_eq("rst_start_busy0", int'(ifa.busy), 0);
    @(negedge clk);
    check_eq("rst_start_busy1", int'(ifa.busy), 0);
    run_sweep(0, gold, -1, 1'b0, "afterrst");

    run_sweep(0, gold, 10, 1'b1, "restartA");
    run_sweep(1, make_tab(2), -1, 1'b0, "o1invB");

    for (int r = 0; r < 6; r++) begin
      rt = gold ^ 16'($urandom & $urandom);
      run_sweep(r % 2, rt, -1, 1'b0, (r % 2 == 0) ? "randA" : "randB");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/minimization_checker.md
# minimization_checker

Sequential self-checking driver for the 3-input/2-output minimization logic. It sweeps the DUT inputs `{i2,i1,i0}` from 0 to 7 and waits a settling interval per vector. It then samples `{o1,o0}`, compares the sample against a stored expected truth table, and reports a per-vector fail map, an error count and a pass flag. It sits on the far side of the minimization interface: it drives `i2..i0` and consumes `o1,o0`, for bring-up and on-board self-test.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `EXPECTED`, default 16'h6E76: expected `{o1,o0}` per vector. Bits `[2k+1:2k]` hold the value for vector k, so k0=10, k1=01, k2=11, k3=01, k4=10, k5=11, k6=10, k7=01.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin a sweep; sampled in IDLE only.
- `o1`, `o0`  in  1 each  DUT outputs under test.
- `i2`, `i1`, `i0`  out  1 each  registered DUT stimulus.
- `busy`  out  1  high from the cycle after `start` until DONE is left.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  1 when the last sweep had zero mismatches.
- `err_cnt`  out  4  mismatch count of the last or current sweep (0..8).
- `fail_map`  out  8  bit k set when vector k mismatched.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- **IDLE:**
  - `start`=1 → SETTLE, `{i2,i1,i0}`←0, settle counter←0, `err_cnt`←0, `fail_map`←0, `pass`←0.
  - `start`=0 → stay in IDLE; all results hold.
- **SETTLE:**
  - Counter increments each cycle.
  - When counter = SETTLE-1 → CHECK.
- **CHECK:**
  - Compare `{o1,o0}` with `EXPECTED[2k+1:2k]`, where k = `{i2,i1,i0}`.
  - On mismatch: `fail_map[k]`←1 and `err_cnt`+1.
  - If k=7 → DONE.
  - Otherwise k←k+1, counter←0, → SETTLE.
- **DONE:**
  - `done`=1 and `pass`←(final `err_cnt`==0), including the CHECK-cycle update.
  - Next cycle → IDLE.
- Stimulus outputs hold the last applied vector while in IDLE.
- `start` in any state other than IDLE is ignored; it is not queued.
- `err_cnt` cannot overflow: the maximum is 8.
- `o1,o0` are treated as synchronous to `clk`; no synchronizer is included.

## Timing
- Reset values: `i2,i1,i0`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_map`=0; FSM goes to IDLE.
- Cycle 0: `start` sampled high. Cycle 1: first vector 0 is presented and `busy`=1.
- Each vector is presented for SETTLE+1 cycles and sampled at the end of its CHECK cycle.
- Full sweep:
  - `done` is high in cycle 8·(SETTLE+1)+1 after the `start` edge.
  - With SETTLE=2, `done` is high in cycle 25.
  - `busy` falls the cycle after `done`.
- `rst` has priority over everything and may arrive mid-sweep: next cycle all outputs are at reset values and the FSM is in IDLE.
- `start` and `rst` high in the same cycle → reset wins; no sweep starts.
- `start` high in the DONE cycle is ignored; `start` is accepted on the following IDLE cycle.

## Configuration
- `MINCHK_STOP_ON_FAIL_EN`:
  - **Defined:** a mismatch in CHECK goes directly to DONE. The failing vector remains on `i2,i1,i0` after DONE, so `err_cnt` ≤ 1 and `fail_map` has at most one bit set.
  - **Undefined:** all 8 vectors are always swept, and mismatches are accumulated.

## Test plan
- **Correct DUT, SETTLE=2:**
  - Bench model o1=(i2&~i1)|~i0, o0=i0|(i1&~i2); pulse `start`.
  - Required: `done` in cycle 25, `pass`=1, `err_cnt`=0, `fail_map`=8'h00, stimulus sequence 0..7.
- **`o0` stuck at 0, macro undefined:**
  - Required: `err_cnt`=5, `fail_map`=8'hAE, `pass`=0.
- **`o0` stuck at 0, macro defined:**
  - Required: `done` after the vector-1 CHECK, `err_cnt`=1, `fail_map`=8'h02, `{i2,i1,i0}`=3'b001 held.
- **Reset mid-sweep:**
  - Assert `rst` for one cycle during vector 4.
  - Required: next cycle all outputs are 0 and FSM is in IDLE; a later `start` performs a full clean sweep with `pass`=1.
- **`start` while busy:**
  - Pulse `start` again at vector 3.
  - Required: no restart, single `done` at cycle 25, `err_cnt` unaffected.
- **SETTLE=1 with `o1` inverted:**
  - Required: `done` in cycle 17, `err_cnt`=8, `fail_map`=8'hFF.
